// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the core load/store port and the AES block port.
// Optional DMEM_ARB_STATS_EN adds saturating conflict/forced-grant counters.
module dmem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int BURST_LEN  = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    input  logic          aes_req,
    input  logic          aes_we,
    input  logic          aes_burst,
    input  logic [AW-1:0] aes_addr,
    input  logic [DW-1:0] aes_wdata,
    output logic          aes_gnt,
    output logic          aes_abort,
    output logic [DW-1:0] rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]   stat_conflicts,
    output logic [15:0]   stat_forced
`endif
);

    localparam int WW = $clog2(STARVE_MAX + 1);
    localparam int BW = $clog2(BURST_LEN);
    localparam logic [WW-1:0] WAIT_TOP  = WW'(STARVE_MAX);
    localparam logic [BW-1:0] BEAT_LOAD = BW'(BURST_LEN - 1);
    localparam logic [BW-1:0] BEAT_ONE  = BW'(1);

    typedef enum logic {OPEN, LOCK} state_t;

    state_t        state_reg;
    logic [WW-1:0] wait_reg;
    logic [BW-1:0] beat_reg;
    logic          abort_reg;
    logic          both;
    logic          starve;

    assign both      = cpu_req & aes_req;
    assign starve    = (state_reg == OPEN) && both && (wait_reg == WAIT_TOP);
    assign aes_abort = abort_reg;
    assign rdata     = mem_rdata;

    always_comb begin
        cpu_gnt = 1'b0;
        aes_gnt = 1'b0;
        if (state_reg == LOCK) begin
            aes_gnt = aes_req;
        end else if (both) begin
            aes_gnt = starve;
            cpu_gnt = ~starve;
        end else begin
            cpu_gnt = cpu_req;
            aes_gnt = aes_req;
        end
    end

    // Memory bus is quiet (all zero) whenever nobody holds a grant.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (aes_gnt) begin
            mem_we    = aes_we;
            mem_addr  = aes_addr;
            mem_wdata = aes_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= OPEN;
            wait_reg  <= '0;
            beat_reg  <= '0;
            abort_reg <= 1'b0;
        end else begin
            abort_reg <= 1'b0;
            if (!aes_req || aes_gnt) begin
                wait_reg <= '0;
            end else if (wait_reg != WAIT_TOP) begin
                wait_reg <= wait_reg + WW'(1);
            end
            case (state_reg)
                OPEN: begin
                    if (aes_gnt && aes_burst) begin
                        state_reg <= LOCK;
                        beat_reg  <= BEAT_LOAD;
                    end
                end
                LOCK: begin
                    // Dropping the request mid-burst releases the lock and flags it next cycle.
                    if (!aes_req) begin
                        state_reg <= OPEN;
                        beat_reg  <= '0;
                        abort_reg <= 1'b1;
                    end else begin
                        beat_reg <= beat_reg - BW'(1);
                        if (beat_reg == BEAT_ONE) begin
                            state_reg <= OPEN;
                        end
                    end
                end
            endcase
        end
    end

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_conflicts <= '0;
            stat_forced    <= '0;
        end else begin
            if (both && stat_conflicts != 16'hFFFF) begin
                stat_conflicts <= stat_conflicts + 16'd1;
            end
            if (starve && stat_forced != 16'hFFFF) begin
                stat_forced <= stat_forced + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: priority, starvation, locked bursts, abort and reset.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_gnt;
    logic        aes_req, aes_we, aes_burst;
    logic [31:0] aes_addr, aes_wdata;
    logic        aes_gnt, aes_abort;
    logic [31:0] rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stat_conflicts, stat_forced;
`endif

    int total = 0;
    int bad   = 0;

    dmem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_gnt   (cpu_gnt),
        .aes_req   (aes_req),
        .aes_we    (aes_we),
        .aes_burst (aes_burst),
        .aes_addr  (aes_addr),
        .aes_wdata (aes_wdata),
        .aes_gnt   (aes_gnt),
        .aes_abort (aes_abort),
        .rdata     (rdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stat_conflicts (stat_conflicts),
        .stat_forced    (stat_forced)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                         input logic ar, input logic aw, input logic ab,
                         input logic [31:0] aa, input logic [31:0] ad);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        aes_req = ar; aes_we = aw; aes_burst = ab; aes_addr = aa; aes_wdata = ad;
        #1;
    endtask

    // Checks grants, abort and address for the current cycle, prints it, then advances one clock.
    task automatic step(input string tag, input logic ecg, input logic eag,
                        input logic eab, input logic [31:0] eaddr);
        chk({tag, ".cpu_gnt"}, 32'(cpu_gnt), 32'(ecg));
        chk({tag, ".aes_gnt"}, 32'(aes_gnt), 32'(eag));
        chk({tag, ".aes_abort"}, 32'(aes_abort), 32'(eab));
        chk({tag, ".mem_addr"}, mem_addr, eaddr);
        $display("%s cpu_gnt=%0b aes_gnt=%0b abort=%0b mem_we=%0b mem_addr=%0h",
                 tag, cpu_gnt, aes_gnt, aes_abort, mem_we, mem_addr);
        @(posedge clk);
        #1;
    endtask

    initial begin
        mem_rdata = 32'hDEAD_BEEF;
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;

        // Reset state, idle
        chk("rst.mem_we", 32'(mem_we), 32'd0);
        chk("rst.mem_wdata", mem_wdata, 32'd0);
        step("rst", 0, 0, 0, 32'd0);

        // Core store alone
        drive(1, 1, 32'd100, 32'd25, 0, 0, 0, 0, 0);
        chk("cpu_st.mem_we", 32'(mem_we), 32'd1);
        chk("cpu_st.mem_wdata", mem_wdata, 32'd25);
        chk("cpu_st.rdata", rdata, 32'hDEAD_BEEF);
        step("cpu_st", 1, 0, 0, 32'd100);

        // AES store alone
        drive(0, 0, 0, 0, 1, 1, 0, 32'h40, 32'h1234);
        chk("aes_st.mem_we", 32'(mem_we), 32'd1);
        chk("aes_st.mem_wdata", mem_wdata, 32'h1234);
        step("aes_st", 0, 1, 0, 32'h40);

        // Starvation: clean reset so stats start at zero
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(1, 0, 32'h10, 0, 1, 0, 0, 32'h300, 0);
        for (int i = 0; i < 18; i++) begin
            if (i == 8 || i == 17)
                step($sformatf("starve%0d", i), 0, 1, 0, 32'h300);
            else
                step($sformatf("starve%0d", i), 1, 0, 0, 32'h10);
        end
`ifdef DMEM_ARB_STATS_EN
        chk("stat_conflicts", 32'(stat_conflicts), 32'd18);
        chk("stat_forced", 32'(stat_forced), 32'd2);
`endif
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("idle1", 0, 0, 0, 32'd0);

        // Full locked burst with core pressure
        drive(0, 0, 0, 0, 1, 0, 1, 32'h200, 0);
        step("burst0", 0, 1, 0, 32'h200);
        drive(1, 0, 32'h10, 0, 1, 0, 0, 32'h204, 0);
        step("burst1", 0, 1, 0, 32'h204);
        drive(1, 0, 32'h10, 0, 1, 0, 0, 32'h208, 0);
        step("burst2", 0, 1, 0, 32'h208);
        drive(1, 0, 32'h10, 0, 1, 0, 0, 32'h20C, 0);
        step("burst3", 0, 1, 0, 32'h20C);
        drive(1, 0, 32'h10, 0, 1, 0, 0, 32'h210, 0);
        step("burst_end", 1, 0, 0, 32'h10);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("idle2", 0, 0, 0, 32'd0);

        // Burst aborted after two beats
        drive(0, 0, 0, 0, 1, 0, 1, 32'h400, 0);
        step("abort_b0", 0, 1, 0, 32'h400);
        drive(1, 0, 32'h20, 0, 1, 0, 0, 32'h404, 0);
        step("abort_b1", 0, 1, 0, 32'h404);
        drive(1, 0, 32'h20, 0, 0, 0, 0, 0, 0);
        step("abort_drop", 0, 0, 0, 32'd0);
        step("abort_pulse", 1, 0, 1, 32'h20);
        step("abort_clear", 1, 0, 0, 32'h20);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("idle3", 0, 0, 0, 32'd0);

        // Reset during beat 2 of a burst
        drive(0, 0, 0, 0, 1, 0, 1, 32'h500, 0);
        step("rburst_b0", 0, 1, 0, 32'h500);
        reset = 1'b0;
        drive(1, 0, 32'h30, 0, 1, 0, 0, 32'h504, 0);
        step("rburst_b1", 0, 1, 0, 32'h504);
        reset = 1'b1;
        #1;
`ifdef DMEM_ARB_STATS_EN
        chk("stat_conflicts_rst", 32'(stat_conflicts), 32'd0);
`endif
        step("rburst_open", 1, 0, 0, 32'h30);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("rburst_idle", 0, 0, 0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
